// File: rtl/mem_pkg.sv
// Shared constants for the parametrised lab memory family.
package mem_pkg;
   localparam logic MODE_RAM  = 1'b0;
   localparam logic MODE_FIFO = 1'b1;
   localparam int   DEF_WIDTH = 8;
   localparam int   DEF_AW    = 3;
endpackage

// File: rtl/tsb_param.sv
// WIDTH-bit tri-state buffer: drives the shared bus only while enabled.
module tsb_param #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in_i,
   input  logic             en_i,
   output wire  [WIDTH-1:0] out_o
);
   assign out_o = en_i ? in_i : {WIDTH{1'bz}};
endmodule

// File: rtl/memory_param.sv
// Parametrised RAM / circular FIFO with registered, tri-stated read port.
module memory_param
   import mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AW    = DEF_AW
) (
   input  logic             CLK,
   input  logic             R,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    A,
   input  logic             CS,
   input  logic             RE,
   input  logic             WE,
   input  logic             MODE,
   output wire  [WIDTH-1:0] out,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             err
);
   localparam int          DEPTH    = 2 ** AW;
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_q;
   logic             oe_q, oe_d;
   logic             err_q, err_d;
   logic             mode_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   logic             mode_switch, fifo_mode, access;
   logic             push, pop, ram_wr, ram_rd, wr_en;
   logic [AW-1:0]    wr_addr, rd_addr;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign err   = err_q;

   always_comb begin
      mode_switch = (MODE != mode_q);
      fifo_mode   = (mode_q == MODE_FIFO);
      // A mode-switch edge performs no access at all
      access      = CS && !mode_switch;
      pop         = access && fifo_mode && RE && !empty;
      push        = access && fifo_mode && WE && (!full || pop);
      ram_wr      = access && !fifo_mode && WE;
      ram_rd      = access && !fifo_mode && RE;
      wr_en       = push || ram_wr;
      wr_addr     = fifo_mode ? wr_ptr_q : A;
      rd_addr     = fifo_mode ? rd_ptr_q : A;
      oe_d        = pop || ram_rd;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      if (mode_switch) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         err_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
         if (access && fifo_mode && ((RE && empty) || (WE && full && !pop)))
            err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q     <= '0;
         oe_q     <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mode_q   <= MODE;
      end else begin
         // Read samples the old word, so same-line read/write is read-before-write
         if (wr_en) mem_q[wr_addr] <= D;
         if (oe_d)  rd_q <= mem_q[rd_addr];
         oe_q     <= oe_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mode_q   <= MODE;
      end
   end

   tsb_param #(.WIDTH(WIDTH)) u_tsb (
      .in_i  (rd_q),
      .en_i  (oe_q),
      .out_o (out)
   );
endmodule

// File: tb/tb_memory_param.sv
// Scenario bench for memory_param: 8x8 instance against a behavioural model, plus a 32x32 FIFO instance.
module tb_memory_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int fails     = 0;

   // ---------------- 8-bit / 8-line instance ----------------
   logic       r, cs, re, we, mode;
   logic [2:0] a;
   logic [7:0] d;
   tri   [7:0] bus;
   logic       full, empty, err;
   logic [3:0] count;
   logic       probe_en  = 1'b0;
   logic [7:0] probe_val = '0;
   assign bus = probe_en ? probe_val : 8'bz;

   memory_param #(.WIDTH(8), .AW(3)) dut (
      .CLK(clk), .R(r), .D(d), .A(a), .CS(cs), .RE(re), .WE(we), .MODE(mode),
      .out(bus), .full(full), .empty(empty), .count(count), .err(err)
   );

   // ---------------- 32-bit / 32-line instance ----------------
   logic        r2, cs2, re2, we2, mode2;
   logic [4:0]  a2;
   logic [31:0] d2;
   tri   [31:0] bus2;
   logic        full2, empty2, err2;
   logic [5:0]  count2;
   logic        probe2_en  = 1'b0;
   logic [31:0] probe2_val = '0;
   assign bus2 = probe2_en ? probe2_val : 32'bz;

   memory_param #(.WIDTH(32), .AW(5)) dut2 (
      .CLK(clk), .R(r2), .D(d2), .A(a2), .CS(cs2), .RE(re2), .WE(we2), .MODE(mode2),
      .out(bus2), .full(full2), .empty(empty2), .count(count2), .err(err2)
   );

   // ---------------- behavioural model (8x8) ----------------
   logic [7:0] mem_m [8];
   int         cnt_m, wr_i, rd_i;
   bit         err_m, mode_m, oe_m;
   logic [7:0] out_m;

   task automatic model_reset(input bit m);
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
      cnt_m = 0; wr_i = 0; rd_i = 0; err_m = 0; mode_m = m; oe_m = 0; out_m = '0;
   endtask

   task automatic model_edge(input bit c, input bit rr, input bit w, input bit m,
                             input int ad, input logic [7:0] dd);
      bit p, pu;
      if (m != mode_m) begin
         mode_m = m; cnt_m = 0; wr_i = 0; rd_i = 0; err_m = 0; oe_m = 0;
         return;
      end
      if (!c) begin
         oe_m = 0;
         return;
      end
      if (!mode_m) begin
         oe_m = rr;
         if (rr) out_m = mem_m[ad];
         if (w)  mem_m[ad] = dd;
      end else begin
         p  = rr && (cnt_m > 0);
         pu = w && ((cnt_m < 8) || p);
         if ((rr && cnt_m == 0) || (w && cnt_m == 8 && !p)) err_m = 1;
         oe_m = p;
         if (p)  begin out_m = mem_m[rd_i]; rd_i = (rd_i + 1) % 8; end
         if (pu) begin mem_m[wr_i] = dd;   wr_i = (wr_i + 1) % 8; end
         cnt_m = cnt_m + int'(pu) - int'(p);
      end
   endtask

   // One clock edge on the small instance; returns at edge + 1.
   task automatic cyc(input bit c, input bit rr, input bit w, input bit m,
                      input int ad, input logic [7:0] dd);
      cs = c; re = rr; we = w; mode = m; a = ad[2:0]; d = dd;
      @(posedge clk);
      model_edge(c, rr, w, m, ad, dd);
      #1;
   endtask

   // Reads the bus undriven by the bench, then with a random probe driver that shows through only if the DUT is Z.
   task automatic sample(output logic [7:0] drv, output logic [7:0] prb, output logic [7:0] pv);
      drv = bus;
      pv  = 8'($urandom);
      probe_val = pv; probe_en = 1'b1;
      #1;
      prb = bus;
      probe_en = 1'b0;
      #0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      logic [7:0] drv, prb, pv;
      r = 1; r2 = 1; cs = 0; re = 0; we = 0; mode = 0; a = 0; d = 0;
      cs2 = 0; re2 = 0; we2 = 0; mode2 = 0; a2 = 0; d2 = 0;
      #2;
      model_reset(0);
      tests_run++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d, expected 0", count); end
      tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_flags: empty=%b full=%b, expected 1/0", empty, full); end
      tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, expected 0", err); end
      sample(drv, prb, pv);
      tests_run++; if (prb !== pv) begin fails++; $display("FAIL reset_out_z: bus=%h with probe %h, expected Z", prb, pv); end
      @(negedge clk); r = 0; r2 = 0;
      $display("[TB] reset checked");
   endtask

   task automatic test_ram_rw;
      logic [7:0] drv, prb, pv;
      cyc(1, 0, 1, 0, 5, 8'h25);
      cyc(1, 1, 0, 0, 5, 8'h00);
      sample(drv, prb, pv);
      tests_run++; if (drv !== 8'h25) begin fails++; $display("FAIL ram_read: out=%h, expected 25", drv); end
      cyc(1, 0, 0, 0, 5, 8'h00);
      sample(drv, prb, pv);
      tests_run++; if (prb !== pv) begin fails++; $display("FAIL ram_re0_z: bus=%h with probe %h, expected Z", prb, pv); end
      tests_run++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL ram_flags: count=%0d empty=%b full=%b, expected 0/1/0", count, empty, full); end
      $display("[TB] ram write/read A=5 -> %h", drv);
   endtask

   task automatic test_ram_rbw_cs;
      logic [7:0] drv, prb, pv;
      cyc(1, 0, 1, 0, 2, 8'h09);
      cyc(1, 1, 1, 0, 2, 8'h13);
      sample(drv, prb, pv);
      tests_run++; if (drv !== 8'h09) begin fails++; $display("FAIL ram_rbw_old: out=%h, expected 09", drv); end
      cyc(1, 1, 0, 0, 2, 8'h00);
      sample(drv, prb, pv);
      tests_run++; if (drv !== 8'h13) begin fails++; $display("FAIL ram_rbw_new: out=%h, expected 13", drv); end
      cyc(0, 1, 1, 0, 2, 8'hFF);
      sample(drv, prb, pv);
      tests_run++; if (prb !== pv) begin fails++; $display("FAIL cs0_z: bus=%h with probe %h, expected Z", prb, pv); end
      cyc(1, 1, 0, 0, 2, 8'h00);
      sample(drv, prb, pv);
      tests_run++; if (drv !== 8'h13) begin fails++; $display("FAIL cs0_nowrite: out=%h, expected 13", drv); end
      $display("[TB] ram read-before-write and chip select checked");
   endtask

   task automatic test_fifo_fill;
      logic [7:0] drv, prb, pv;
      cyc(1, 0, 0, 1, 0, 8'h00);
      tests_run++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL fifo_switch: count=%0d empty=%b, expected 0/1", count, empty); end
      for (int i = 1; i <= 8; i++) cyc(1, 0, 1, 1, 0, 8'(i));
      tests_run++; if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin fails++; $display("FAIL fifo_full: count=%0d full=%b empty=%b, expected 8/1/0", count, full, empty); end
      cyc(1, 0, 1, 1, 0, 8'hAA);
      tests_run++; if (err !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL fifo_overflow: err=%b count=%0d, expected 1/8", err, count); end
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 1, 0, 1, 0, 8'h00);
         sample(drv, prb, pv);
         tests_run++; if (drv !== 8'(i)) begin fails++; $display("FAIL fifo_pop%0d: out=%h, expected %h", i, drv, 8'(i)); end
      end
      tests_run++; if (empty !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL fifo_drained: empty=%b count=%0d, expected 1/0", empty, count); end
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0, 8'hB0 + 8'(i));
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 1, 0, 8'h00);
         sample(drv, prb, pv);
         tests_run++; if (drv !== 8'hB0 + 8'(i)) begin fails++; $display("FAIL fifo_wrap%0d: out=%h, expected %h", i, drv, 8'hB0 + 8'(i)); end
      end
      $display("[TB] fifo fill/overflow/drain/wrap checked");
   endtask

   task automatic test_fifo_simul;
      logic [7:0] drv, prb, pv;
      logic [7:0] oldest;
      oldest = 8'($urandom);
      cyc(1, 0, 1, 1, 0, oldest);
      for (int i = 1; i < 8; i++) cyc(1, 0, 1, 1, 0, 8'($urandom));
      cyc(1, 1, 1, 1, 0, 8'h55);
      sample(drv, prb, pv);
      tests_run++; if (drv !== oldest) begin fails++; $display("FAIL full_pushpop_out: out=%h, expected %h", drv, oldest); end
      tests_run++; if (count !== 4'd8 || full !== 1'b1) begin fails++; $display("FAIL full_pushpop_count: count=%0d full=%b, expected 8/1", count, full); end
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 0, 1, 0, 8'h00);
         sample(drv, prb, pv);
         tests_run++; if (drv !== out_m) begin fails++; $display("FAIL simul_drain%0d: out=%h, expected %h", i, drv, out_m); end
      end
      cyc(1, 1, 0, 1, 0, 8'h00);
      sample(drv, prb, pv);
      tests_run++; if (prb !== pv) begin fails++; $display("FAIL underflow_z: bus=%h with probe %h, expected Z", prb, pv); end
      tests_run++; if (err !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL underflow_err: err=%b count=%0d, expected 1/0", err, count); end
      cyc(1, 1, 1, 1, 0, 8'h77);
      sample(drv, prb, pv);
      tests_run++; if (prb !== pv || count !== 4'd1) begin fails++; $display("FAIL empty_pushpop: bus=%h probe %h count=%0d, expected Z and 1", prb, pv, count); end
      cyc(1, 1, 0, 1, 0, 8'h00);
      sample(drv, prb, pv);
      tests_run++; if (drv !== 8'h77) begin fails++; $display("FAIL empty_pushpop_data: out=%h, expected 77", drv); end
      $display("[TB] fifo simultaneous push/pop and underflow checked");
   endtask

   task automatic test_mode_switch;
      logic [7:0] drv, prb, pv;
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0, 8'($urandom));
      cyc(1, 0, 0, 0, 0, 8'h00);
      tests_run++; if (count !== 4'd0 || err !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL switch_clear: count=%0d err=%b empty=%b, expected 0/0/1", count, err, empty); end
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, i, 8'h00);
         sample(drv, prb, pv);
         tests_run++; if (drv !== out_m) begin fails++; $display("FAIL switch_retain A=%0d: out=%h, expected %h", i, drv, out_m); end
      end
      $display("[TB] mode switch checked");
   endtask

   task automatic test_random;
      logic [7:0] drv, prb, pv;
      bit c, rr, w, m;
      for (int n = 0; n < 300; n++) begin
         c  = ($urandom_range(0, 9) != 0);
         m  = ($urandom_range(0, 19) != 0);
         rr = $urandom_range(0, 1) != 0;
         w  = $urandom_range(0, 1) != 0;
         cyc(c, rr, w, m, $urandom_range(0, 7), 8'($urandom));
         sample(drv, prb, pv);
         tests_run++;
         if (count !== 4'(cnt_m) || full !== (cnt_m == 8) || empty !== (cnt_m == 0) || err !== err_m) begin
            fails++; $display("FAIL rand%0d_state: count=%0d full=%b empty=%b err=%b, expected %0d/%b/%b/%b",
                              n, count, full, empty, err, cnt_m, cnt_m == 8, cnt_m == 0, err_m);
         end
         tests_run++;
         if (oe_m ? (drv !== out_m) : (prb !== pv)) begin
            fails++; $display("FAIL rand%0d_out: bus=%h probed=%h, expected %s %h", n, drv, prb, oe_m ? "data" : "Z(probe)", oe_m ? out_m : pv);
         end
      end
      $display("[TB] random sequence of 300 cycles done");
   endtask

   task automatic test_async_reset;
      logic [7:0] drv, prb, pv;
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, 8'($urandom));
      #2;
      r = 1; mode = 0;
      #1;
      model_reset(0);
      tests_run++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL async_reset_flags: count=%0d empty=%b full=%b err=%b", count, empty, full, err); end
      sample(drv, prb, pv);
      tests_run++; if (prb !== pv) begin fails++; $display("FAIL async_reset_z: bus=%h with probe %h, expected Z", prb, pv); end
      @(negedge clk); r = 0; cs = 0; re = 0; we = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 0, 0, i, 8'h00);
         sample(drv, prb, pv);
         tests_run++; if (drv !== 8'h00) begin fails++; $display("FAIL async_reset_mem A=%0d: out=%h, expected 00", i, drv); end
      end
      $display("[TB] async reset checked");
   endtask

   task automatic test_wide;
      logic [31:0] q [$];
      logic [31:0] v, exp_v, pv;
      mode2 = 1; cs2 = 1; re2 = 0; we2 = 0;
      @(posedge clk); #1;
      tests_run++; if (count2 !== 6'd0 || empty2 !== 1'b1) begin fails++; $display("FAIL wide_switch: count=%0d empty=%b", count2, empty2); end
      we2 = 1;
      for (int i = 0; i < 32; i++) begin
         v = $urandom; d2 = v;
         @(posedge clk); #1;
         q.push_back(v);
      end
      tests_run++; if (count2 !== 6'd32 || full2 !== 1'b1) begin fails++; $display("FAIL wide_full: count=%0d full=%b, expected 32/1", count2, full2); end
      d2 = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      tests_run++; if (err2 !== 1'b1 || count2 !== 6'd32) begin fails++; $display("FAIL wide_overflow: err=%b count=%0d, expected 1/32", err2, count2); end
      we2 = 0; re2 = 1;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         exp_v = q.pop_front();
         tests_run++; if (bus2 !== exp_v) begin fails++; $display("FAIL wide_pop%0d: out=%h, expected %h", i, bus2, exp_v); end
      end
      re2 = 0;
      tests_run++; if (empty2 !== 1'b1 || err2 !== 1'b1) begin fails++; $display("FAIL wide_drained: empty=%b err=%b, expected 1/1", empty2, err2); end
      we2 = 1;
      for (int i = 0; i < 5; i++) begin d2 = $urandom; @(posedge clk); #1; end
      #2;
      r2 = 1;
      #1;
      pv = $urandom; probe2_val = pv; probe2_en = 1'b1; #1;
      tests_run++; if (bus2 !== pv) begin fails++; $display("FAIL wide_reset_z: bus=%h with probe %h, expected Z", bus2, pv); end
      probe2_en = 1'b0;
      tests_run++; if (count2 !== 6'd0 || empty2 !== 1'b1 || err2 !== 1'b0) begin fails++; $display("FAIL wide_reset_flags: count=%0d empty=%b err=%b", count2, empty2, err2); end
      @(negedge clk); r2 = 0; cs2 = 0; we2 = 0;
      $display("[TB] wide 32x32 fifo checked");
   endtask

   initial begin
      test_reset();
      test_ram_rw();
      test_ram_rbw_cs();
      test_fifo_fill();
      test_fifo_simul();
      test_mode_switch();
      test_random();
      test_async_reset();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule

// File: doc/memory_param.md
Name: memory_param

Overview:
- Parametrised successor of the fixed 8/32/128-byte memories: WIDTH-bit words, 2**AW lines, chip select, registered read, tri-stated output bus.
- Adds a runtime FIFO mode. The same array becomes a circular buffer with push/pop, full/empty flags, occupancy count and a sticky error flag.
- Sits on the shared lab data bus; several instances may drive the same `out` net because `out` is Z when not reading.

Parameters:
WIDTH, 8, data word width in bits (>=1)
AW, 3, address width; DEPTH = 2**AW lines (AW>=1)

Ports:
CLK  input  1  system clock, rising-edge active
R  input  1  reset; asynchronous, active-high
D  input  WIDTH  write data
A  input  AW  line address (RAM mode only; ignored in FIFO mode)
CS  input  1  chip select; 0 = no access, out = Z
RE  input  1  read enable (RAM read / FIFO pop)
WE  input  1  write enable (RAM write / FIFO push)
MODE  input  1  0 = RAM, 1 = FIFO
out  output  WIDTH  registered read data; Z when not valid
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
count  output  AW+1  FIFO occupancy, 0..DEPTH
err  output  1  sticky: FIFO overflow/underflow attempted

Behaviour:
- One clock CLK; reset R is asynchronous, active-high.
- Reset (R=1, immediate, not waiting for CLK):
  - all DEPTH lines = 0; wr_ptr = rd_ptr = 0; count = 0; err = 0.
  - rd_q = 0; oe_q = 0, so out = Z.
  - mode_q = MODE; full = 0, empty = 1.
  - Reset mid-operation aborts any access in that cycle; nothing is written.
- Output: out = oe_q ? rd_q : Z. Read latency is 1 cycle; data appears after the edge that sampled RE.
- CS=0 at an edge: no write, no pop; oe_q <= 0.
- Mode register mode_q follows MODE each edge.
  - If MODE != mode_q at an edge, that edge is a mode-switch cycle: wr_ptr, rd_ptr, count, err and oe_q clear to 0.
  - No access is performed in a mode-switch cycle. Memory contents are retained.
- RAM mode (mode_q = 0, CS = 1):
  - WE=1: mem[A] <= D.
  - RE=1: rd_q <= mem[A], oe_q <= 1. RE=0: oe_q <= 0.
  - RE=WE=1 at the same A is read-before-write: out shows the old word, and the new word is stored.
  - count = 0, empty = 1, full = 0 are held throughout.
- FIFO mode (mode_q = 1, CS = 1):
  - push = WE & (~full | pop). Write mem[wr_ptr] <= D; wr_ptr increments, wrapping DEPTH-1 -> 0.
  - pop = RE & ~empty. rd_q <= mem[rd_ptr], oe_q <= 1; rd_ptr increments with wrap.
  - RE=1 while empty: underflow. oe_q <= 0, err <= 1, no pointer change. There is no bypass of same-cycle push data.
  - WE=1 while full and no pop: overflow. Data dropped, err <= 1.
  - Push and pop together when full: both succeed, count unchanged.
  - Push and pop together when empty: push only (plus underflow), count -> 1.
  - count += push - pop; full = (count == DEPTH); empty = (count == 0). Flags derive from the count register and are valid in the cycle after the edge.
  - err clears only on reset or a mode switch.

Decomposition:
- Shared package mem_pkg holds:
  - constants MODE_RAM = 1'b0, MODE_FIFO = 1'b1;
  - default WIDTH = 8, AW = 3.
- One natural sub-module, tsb_param: WIDTH-bit tri-state buffer (in, enable, out), the parametrised form of the existing tsb. It drives `out` from rd_q/oe_q.
- The array, pointers and control logic stay in memory_param.

Test Plan:
- RAM write/read: MODE=0, CS=1, WE=1, D=8'h25, A=3'd5; next cycle WE=0, RE=1, A=5 -> out=8'h25 one edge later. Then RE=0 -> out=Z.
- RAM read-before-write and chip select:
  - A=2 holds 8'h09; RE=WE=1, D=8'h13 -> out=8'h09; next read -> 8'h13.
  - CS=0 with WE=1, D=8'hFF -> mem unchanged, out=Z.
- FIFO fill, wrap and overflow:
  - MODE=1 (one switch cycle), then push 8'h01..8'h08 -> full=1, count=8.
  - Push 8'hAA -> err=1, count=8.
  - Pop 8 times -> out 01..08 in order, empty=1.
  - Push/pop 3 more -> wrap-around data correct.
- FIFO simultaneous and underflow:
  - When full, RE=WE=1, D=8'h55 -> out = oldest word, count stays 8.
  - When empty, RE=1 -> out=Z, err=1, count=0.
  - When empty, RE=WE=1, D=8'h77 -> count=1, out=Z; next pop gives 8'h77.
- Mode switch:
  - FIFO holding 3 words, MODE->0 -> count=0, err=0, empty=1.
  - RAM read of A=0..2 returns the FIFO-written data (contents retained).
- Async reset: assert R between clock edges during a FIFO burst -> immediately all counts/flags cleared, out=Z, any address read returns 8'h00. Repeat with WIDTH=32, AW=5: count reaches 32 at full.
